mips_imem_encoder: RTL and testbench

Sequential instruction encoder and instruction-memory loader: the producing end of the opcode/funct interface that `mips_decode` consumes. Accepts instruction descriptors (format, opcode, funct, register, immediate and target fields) over a valid/ready handshake. Packs each descriptor into a 32-bit MIPS word, buffers it in a small FIFO, and writes it to instruction memory at sequential word addresses. Used to boot-load test programs into the processor's instruction memory before the core runs.

---
 rtl/mips_imem_encoder_if.sv | 41 ++++
 rtl/mips_imem_encoder.sv | 117 +++++++++++
 tb/tb_mips_imem_encoder.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_imem_encoder_if.sv
// Descriptor channel (producer -> encoder) and instruction-memory write channel
// (encoder -> memory) used by mips_imem_encoder.
interface mips_desc_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [1:0]  fmt;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [25:0] target;

    modport master (
        output in_valid, in_last, fmt, opcode, funct, rs, rt, rd, shamt, imm, target,
        input  in_ready
    );
    modport slave (
        input  in_valid, in_last, fmt, opcode, funct, rs, rt, rd, shamt, imm, target,
        output in_ready
    );
endinterface

interface mips_imem_wr_if;
    logic        mem_we;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;

    modport master (
        output mem_we, mem_addr, mem_data,
        input  mem_ready
    );
    modport slave (
        input  mem_we, mem_addr, mem_data,
        output mem_ready
    );
endinterface

// File: rtl/mips_imem_encoder.sv
// Packs MIPS R/I/J instruction descriptors into 32-bit words, buffers them in a
// small FIFO and writes them to instruction memory at sequential word addresses.
module mips_imem_encoder #(
    parameter logic [31:0] BASE  = 32'h0040_0000,
    parameter int          DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    mips_desc_if.slave      desc,
    mips_imem_wr_if.master  wr,
    output logic            done,
    output logic            err,
    output logic [15:0]     count
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] fifo_mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic [31:0] addr;
    logic        last_seen;
    logic [31:0] enc_word;
    logic        fifo_empty, fifo_full;
    logic        accept, push, fire;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign desc.in_ready = (state == LOAD) && !fifo_full && !last_seen && !start;
    assign accept        = desc.in_valid && desc.in_ready;
    assign push          = accept && (desc.fmt != 2'd3);

    assign wr.mem_we   = (state == LOAD) && !fifo_empty;
    assign wr.mem_data = fifo_empty ? 32'd0 : fifo_mem[rd_ptr[AW-1:0]];
    assign wr.mem_addr = addr;
    assign fire        = wr.mem_we && wr.mem_ready;

    // Done is visible as soon as the session has drained, one cycle ahead of the DONE state.
    assign done = (state == DONE) || ((state == LOAD) && last_seen && fifo_empty);

    always_comb begin
        enc_word = 32'd0;
        unique case (desc.fmt)
            2'd0:    enc_word = {desc.opcode, desc.rs, desc.rt, desc.rd, desc.shamt, desc.funct};
            2'd1:    enc_word = {desc.opcode, desc.rs, desc.rt, desc.imm};
            2'd2:    enc_word = {desc.opcode, desc.target};
            default: enc_word = 32'd0;
        endcase
    end

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        if (start)
            state_nxt = LOAD;
        else if ((state == LOAD) && last_seen && fifo_empty && !fire)
            state_nxt = DONE;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            addr      <= BASE;
            count     <= 16'd0;
            err       <= 1'b0;
            last_seen <= 1'b0;
        end else if (start) begin
            // Flush wins over any write firing in the same cycle.
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            addr      <= BASE;
            count     <= 16'd0;
            err       <= 1'b0;
            last_seen <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (fire) begin
                rd_ptr <= rd_ptr + 1'b1;
                addr   <= addr + 32'd4;
                if (count != 16'hFFFF)
                    count <= count + 16'd1;
            end
            if (accept) begin
                if (desc.fmt == 2'd3)
                    err <= 1'b1;
                if (desc.in_last)
                    last_seen <= 1'b1;
            end
        end
    end

    // NOTE: FIFO storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr[AW-1:0]] <= enc_word;
    end

endmodule

// File: tb/tb_mips_imem_encoder.sv
// Scoreboard bench for mips_imem_encoder: expected words are queued on accept
// and compared, with their addresses, whenever a memory write fires.
module tb_mips_imem_encoder;

    localparam logic [31:0] BASE = 32'h0040_0000;

    typedef struct {
        logic [1:0]  fmt;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [15:0] imm;
        logic [25:0] tgt;
    } desc_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        done;
    logic        err;
    logic [15:0] count;

    mips_desc_if    dif ();
    mips_imem_wr_if wif ();

    mips_imem_encoder #(.BASE(BASE), .DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .desc  (dif),
        .wr    (wif),
        .done  (done),
        .err   (err),
        .count (count)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q [$];
    logic [31:0] exp_addr = BASE;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] encode(input desc_t d);
        case (d.fmt)
            2'd0: return (32'(d.op) << 26) | (32'(d.rs) << 21) | (32'(d.rt) << 16)
                       | (32'(d.rd) << 11) | (32'(d.sh) << 6) | 32'(d.fn);
            2'd1: return (32'(d.op) << 26) | (32'(d.rs) << 21) | (32'(d.rt) << 16) | 32'(d.imm);
            default: return (32'(d.op) << 26) | 32'(d.tgt);
        endcase
    endfunction

    // Unused fields carry junk so the encoder must ignore them.
    function automatic desc_t mk_r(input logic [5:0] op, input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
        return '{fmt: 2'd0, op: op, fn: fn, rs: rs, rt: rt, rd: rd, sh: sh, imm: 16'hBEEF, tgt: 26'h3ABCDEF};
    endfunction

    function automatic desc_t mk_i(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
        return '{fmt: 2'd1, op: op, fn: 6'h3F, rs: rs, rt: rt, rd: 5'h1F, sh: 5'h1F, imm: imm, tgt: 26'h3FFFFFF};
    endfunction

    function automatic desc_t mk_j(input logic [5:0] op, input logic [25:0] tgt);
        return '{fmt: 2'd2, op: op, fn: 6'h15, rs: 5'h0A, rt: 5'h15, rd: 5'h0A, sh: 5'h15, imm: 16'h5555, tgt: tgt};
    endfunction

    function automatic desc_t mk_bad();
        return '{fmt: 2'd3, op: 6'h3F, fn: 6'h3F, rs: 5'h1F, rt: 5'h1F, rd: 5'h1F, sh: 5'h1F, imm: 16'hFFFF, tgt: 26'h3FFFFFF};
    endfunction

    always @(negedge clk) begin
        if (reset || start) begin
            exp_q.delete();
            exp_addr <= BASE;
        end else begin
            if (wif.mem_we && wif.mem_ready) begin
                check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    check("wr_data", wif.mem_data, exp_q.pop_front());
                    check("wr_addr", wif.mem_addr, exp_addr);
                    exp_addr <= exp_addr + 32'd4;
                end
            end
            if (dif.in_valid && dif.in_ready && dif.fmt != 2'd3)
                exp_q.push_back(encode('{fmt: dif.fmt, op: dif.opcode, fn: dif.funct, rs: dif.rs, rt: dif.rt,
                                         rd: dif.rd, sh: dif.shamt, imm: dif.imm, tgt: dif.target}));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input desc_t d, input logic last, output int waits);
        dif.fmt      = d.fmt;
        dif.opcode   = d.op;
        dif.funct    = d.fn;
        dif.rs       = d.rs;
        dif.rt       = d.rt;
        dif.rd       = d.rd;
        dif.shamt    = d.sh;
        dif.imm      = d.imm;
        dif.target   = d.tgt;
        dif.in_last  = last;
        dif.in_valid = 1'b1;
        waits = 0;
        @(negedge clk);
        while (!dif.in_ready && waits < 200) begin
            waits++;
            @(negedge clk);
        end
        check("send_accepted", 32'(dif.in_ready), 32'd1);
        tick();
        dif.in_valid = 1'b0;
        dif.in_last  = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        while (!done && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("done", 32'(done), 32'd1);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        desc_t d;
        int    w;

        reset = 1'b1;
        start = 1'b0;
        dif.in_valid = 1'b0;
        dif.in_last  = 1'b0;
        dif.fmt = 2'd0; dif.opcode = '0; dif.funct = '0; dif.rs = '0; dif.rt = '0;
        dif.rd = '0; dif.shamt = '0; dif.imm = '0; dif.target = '0;
        wif.mem_ready = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(dif.in_ready), 32'd0);
        check("rst_mem_we", 32'(wif.mem_we), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_mem_addr", wif.mem_addr, BASE);
        check("rst_mem_data", wif.mem_data, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Single R word: add $3,$1,$2
        wif.mem_ready = 1'b1;
        pulse_start();
        send(mk_r(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 1'b1, w);
        @(negedge clk);
        check("t1_mem_we", 32'(wif.mem_we), 32'd1);
        check("t1_mem_data", wif.mem_data, 32'h0022_1820);
        check("t1_mem_addr", wif.mem_addr, 32'h0040_0000);
        @(negedge clk);
        check("t1_done", 32'(done), 32'd1);
        check("t1_count", 32'(count), 32'd1);
        tick();

        // Back-to-back I/J/I stream
        pulse_start();
        send(mk_i(6'h08, 5'd0, 5'd8, 16'd5), 1'b0, w);
        check("t2_wait0", 32'(w), 32'd0);
        send(mk_j(6'h02, 26'h010_0000), 1'b0, w);
        check("t2_wait1", 32'(w), 32'd0);
        send(mk_i(6'h04, 5'd1, 5'd2, 16'hFFFF), 1'b1, w);
        check("t2_wait2", 32'(w), 32'd0);
        wait_done();
        check("t2_count", 32'(count), 32'd3);
        check("t2_drained", 32'(exp_q.size()), 32'd0);

        // Backpressure: six descriptors into a four-deep FIFO
        wif.mem_ready = 1'b0;
        pulse_start();
        fork
            begin
                desc_t bd;
                int    bw;
                for (int i = 0; i < 6; i++) begin
                    bd = mk_i(6'h0D, 5'(i), 5'(i + 1), 16'(i * 16'h0111));
                    send(bd, i == 5, bw);
                end
            end
            begin
                repeat (8) tick();
                @(negedge clk);
                check("t3_in_ready_full", 32'(dif.in_ready), 32'd0);
                check("t3_queued", 32'(exp_q.size()), 32'd4);
                check("t3_hold_data", wif.mem_data, 32'h3401_0000);
                check("t3_hold_addr", wif.mem_addr, BASE);
                check("t3_count_stall", 32'(count), 32'd0);
                @(posedge clk);
                #1;
                wif.mem_ready = 1'b1;
            end
        join
        wait_done();
        check("t3_count", 32'(count), 32'd6);
        check("t3_drained", 32'(exp_q.size()), 32'd0);

        // Illegal format mid-stream
        pulse_start();
        send(mk_r(6'd0, 5'd5, 5'd6, 5'd4, 5'd0, 6'h22), 1'b0, w);
        send(mk_bad(), 1'b0, w);
        send(mk_i(6'h23, 5'd29, 5'd9, 16'h0010), 1'b1, w);
        check("t4_err", 32'(err), 32'd1);
        wait_done();
        check("t4_count", 32'(count), 32'd2);
        check("t4_next_addr", wif.mem_addr, 32'h0040_0008);
        pulse_start();
        check("t4_err_cleared", 32'(err), 32'd0);
        // An illegal final descriptor still closes the session
        send(mk_bad(), 1'b1, w);
        @(negedge clk);
        check("t4_done_bad_last", 32'(done), 32'd1);
        check("t4_count_bad_last", 32'(count), 32'd0);
        check("t4_err_bad_last", 32'(err), 32'd1);
        tick();

        // Restart while words are buffered and a write fires
        wif.mem_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 3; i++)
            send(mk_j(6'h03, 26'(32'h100 + i)), 1'b0, w);
        wif.mem_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("t5_mem_we", 32'(wif.mem_we), 32'd0);
        check("t5_mem_addr", wif.mem_addr, 32'h0040_0000);
        check("t5_count", 32'(count), 32'd0);
        repeat (4) tick();
        send(mk_i(6'h0F, 5'd0, 5'd1, 16'h1234), 1'b1, w);
        wait_done();
        check("t5_count_after", 32'(count), 32'd1);

        // Asynchronous reset mid-session
        wif.mem_ready = 1'b0;
        pulse_start();
        send(mk_r(6'd0, 5'd7, 5'd8, 5'd9, 5'd2, 6'h00), 1'b0, w);
        send(mk_bad(), 1'b0, w);
        send(mk_i(6'h0C, 5'd3, 5'd4, 16'h00FF), 1'b0, w);
        @(negedge clk);
        check("t6_pre_mem_we", 32'(wif.mem_we), 32'd1);
        check("t6_pre_err", 32'(err), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("t6_mem_we", 32'(wif.mem_we), 32'd0);
        check("t6_in_ready", 32'(dif.in_ready), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        check("t6_err", 32'(err), 32'd0);
        check("t6_mem_data", wif.mem_data, 32'd0);
        @(negedge clk);
        #2;
        reset = 1'b0;
        wif.mem_ready = 1'b1;
        dif.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t6_idle_in_ready", 32'(dif.in_ready), 32'd0);
            check("t6_idle_mem_we", 32'(wif.mem_we), 32'd0);
        end
        check("t6_state_idle", 32'(dut.state), 32'd0);
        check("t6_count", 32'(count), 32'd0);
        dif.in_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
